uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 tx_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of tx_clk.
REQ-005 wr_en  input  1  push request from the bus side.
REQ-006 wr_data  input  8  byte to push.
REQ-007 flush  input  1  synchronous clear of all queued bytes.
REQ-008 full  output  1  high when the FIFO holds DEPTH bytes.
REQ-009 empty  output  1  high when the FIFO holds 0 bytes.
REQ-010 level  output  AW+1  number of bytes currently held, 0..DEPTH.
REQ-011 ovf  output  1  sticky overflow flag (see Configuration).
REQ-012 ovf_clr  input  1  clears ovf.
REQ-013 tx_valid  output  1  head byte available to the transmitter core.
REQ-014 tx_data  output  8  head byte.
REQ-015 tx_ready  input  1  transmitter core accepts the head byte.

Function
REQ-016 Storage SHALL be a circular buffer with a write pointer and a read pointer, each AW bits, plus an AW+1-bit occupancy count.
REQ-017 A push SHALL occur when wr_en=1, full=0 and flush=0; wr_data is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-018 wr_en=1 while full=1 SHALL be discarded, including in a cycle where a pop occurs; stored data and pointers SHALL be unchanged.
REQ-019 tx_valid SHALL equal !empty; tx_data SHALL show the entry at the read pointer (show-ahead); tx_data is don't-care while tx_valid=0.
REQ-020 A pop SHALL occur when tx_valid=1, tx_ready=1 and flush=0; the read pointer increments modulo DEPTH.
REQ-021 tx_valid and tx_data SHALL remain stable until a pop occurs or flush is asserted.
REQ-022 Latency: a push into an empty FIFO at edge N SHALL give tx_valid=1 with that byte on tx_data after edge N.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-024 level SHALL increment on a push-only cycle, decrement on a pop-only cycle, and never leave the range 0..DEPTH.
REQ-025 full SHALL equal (level==DEPTH); empty SHALL equal (level==0); both are derived from registered state only.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering; bytes SHALL exit in push order.
REQ-027 flush=1 SHALL zero both pointers and level at the next edge, with priority over push and pop in that cycle; ovf is unaffected by flush.

Reset
REQ-028 When reset_n=0 at an edge, pointers and level SHALL become 0 and ovf SHALL become 0, giving empty=1, full=0, tx_valid=0.
REQ-029 Reset SHALL have priority over flush, push, pop and ovf_clr; storage contents are not reset.
REQ-030 Reset asserted mid-stream SHALL discard all queued bytes; the first push after release SHALL be the next byte presented.

Configuration
REQ-031 Macro UART_TX_FIFO_OVF_EN: when defined, ovf SHALL set at the edge following a discarded push (REQ-018) and hold until ovf_clr=1 or reset; when set and clear occur together, set SHALL win.
REQ-032 Without UART_TX_FIFO_OVF_EN, ovf SHALL be tied 0 and ovf_clr SHALL be ignored; the port list SHALL be identical in both builds.

Verification
REQ-033 Push 0x55, tx_ready=0 -> after 1 edge: tx_valid=1, tx_data=0x55, level=1; hold 5 cycles with data stable; tx_ready=1 for 1 cycle -> empty=1.
REQ-034 DEPTH=16: push 0x00..0x0F -> full=1, level=16; push 0xAA -> dropped; drain -> 0x00..0x0F in order, no 0xAA.
REQ-035 With level=3, push and pop every cycle for 40 cycles (pointer wrap) -> level stays 3, output order matches input order.
REQ-036 With level=7, assert flush together with wr_en and tx_ready -> next edge: level=0, tx_valid=0, no byte accepted.
REQ-037 UART_TX_FIFO_OVF_EN defined: push while full -> ovf=1; ovf_clr pulse -> ovf=0; push-while-full in the same cycle as ovf_clr -> ovf=1. Macro undefined: ovf stays 0.
REQ-038 With level=5 and tx_valid=1, drive reset_n=0 for 1 edge -> level=0, empty=1, ovf=0; push 0x3C -> tx_data=0x3C next cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO between a bus-side writer and a UART transmitter core (show-ahead head byte).
// Latency : a byte pushed into an empty FIFO at edge N is presented on tx_data/tx_valid after edge N.
// Backpress: pushes while full are dropped (optionally flagged on ovf); the head byte holds until tx_ready.
//
// Ports:
//   tx_clk    - single clock, all state updates on its rising edge
//   reset_n   - synchronous active-low reset (highest priority)
//   wr_en     - push request; wr_data is the byte to push
//   flush     - synchronous clear of all queued bytes (beats push and pop)
//   full      - FIFO holds DEPTH bytes
//   empty     - FIFO holds no bytes
//   level     - bytes currently held, 0..DEPTH
//   ovf       - sticky overflow flag; ovf_clr clears it
//   tx_valid  - head byte available (== !empty)
//   tx_data   - head byte (don't-care while tx_valid=0)
//   tx_ready  - transmitter accepts the head byte
//
// Build option: define UART_TX_FIFO_OVF_EN to enable the sticky overflow
// flag. Without it ovf is tied low and ovf_clr is ignored; the port list is
// the same in both builds.
//
// DEPTH must be a power of two in 2..256, and AW must equal log2(DEPTH).

module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          tx_clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready
);

  // Occupancy value that means "full", sized to the count register.
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // ---------------------------------------------------------------------
  // Status, derived from registered state only
  // ---------------------------------------------------------------------
  assign full     = (count == LVL_FULL);
  assign empty    = (count == '0);
  assign level    = count;
  assign tx_valid = !empty;

  // Show-ahead: the head entry is always visible on tx_data.
  assign tx_data  = mem[rd_ptr];

  // ---------------------------------------------------------------------
  // Transfer qualification
  // ---------------------------------------------------------------------
  // A push is only judged against the full flag at the start of the cycle,
  // so a write arriving while full is dropped even if a pop frees a slot
  // in the same cycle. Flush suppresses both transfers.
  logic push;
  logic pop;
  logic drop;

  assign push = wr_en && !full && !flush;
  assign pop  = tx_valid && tx_ready && !flush;
  assign drop = wr_en && full;

  // ---------------------------------------------------------------------
  // Storage array: not reset, only written on an accepted push
  // ---------------------------------------------------------------------
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Pointers and occupancy count
  // ---------------------------------------------------------------------
  // Pointers are exactly AW bits wide and DEPTH is a power of two, so the
  // natural binary rollover implements the modulo-DEPTH wrap.
  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Push is blocked when full and pop is blocked when empty, so the
      // count can never leave 0..DEPTH.
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // A dropped write sets the flag even in a cycle that also requests a
  // clear, so an overflow is never silently lost. Flush does not touch it.
  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  // Feature disabled: flag tied low, clear input and drop detect unused.
  logic unused_ovf_sig;

  assign unused_ovf_sig = ovf_clr ^ drop;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          tx_clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          ovf_clr;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .tx_clk   (tx_clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 tx_clk = ~tx_clk;

  // Reference model: the FIFO contents as a plain queue, plus the flag.
  logic [7:0] q[$];
  logic       m_ovf;
  int         n_checks;
  int         n_fail;

`ifdef UART_TX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the behavioural rules,
  // then compare every output #1 after the edge.
  task automatic cyc(input logic rst_n_i, input logic we, input logic [7:0] wd,
                     input logic rdy, input logic fl, input logic oc);
    bit was_full;
    reset_n  = rst_n_i;
    wr_en    = we;
    wr_data  = wd;
    tx_ready = rdy;
    flush    = fl;
    ovf_clr  = oc;

    was_full = (q.size() == DEPTH);
    if (!rst_n_i) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (fl) begin
        q.delete();
      end else begin
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (we && !was_full) q.push_back(wd);
      end
      if (OVF_EN) begin
        if (we && was_full) m_ovf = 1'b1;
        else if (oc)        m_ovf = 1'b0;
      end
    end

    @(posedge tx_clk);
    #1;
    chk("level",    32'(level),    32'(q.size()));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    if (q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ovf    = 1'b0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tx_ready = 1'b0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state.
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(0, 1, 8'h11, 1, 1, 1);
    cyc(1, 0, 8'h00, 0, 0, 0);

    // Single push, held head, then one pop.
    cyc(1, 1, 8'h55, 0, 0, 0);
    chk("first_byte", 32'(tx_data), 32'h55);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'($urandom), 0, 0, 0);
    chk("held_byte", 32'(tx_data), 32'h55);
    cyc(1, 0, 8'h00, 1, 0, 0);
    chk("drained_empty", 32'(empty), 32'd1);

    // Fill to DEPTH, drop an extra byte, drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(i), 0, 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    cyc(1, 1, 8'hAA, 0, 0, 0);
    chk("drop_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(tx_data), 32'(i));
      cyc(1, 0, 8'h00, 1, 0, 0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Level 3, then push+pop every cycle across pointer wraps.
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, 8'($urandom), 1, 0, 0);
    chk("stream_level", 32'(level), 32'd3);

    // Level 7, flush with push and pop requested.
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'($urandom), 0, 0, 0);
    chk("pre_flush_level", 32'(level), 32'd7);
    cyc(1, 1, 8'hEE, 1, 1, 0);
    chk("flush_level", 32'(level), 32'd0);

    // Overflow flag: set, clear, set-beats-clear; full push+pop drops write.
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'($urandom), 0, 0, 0);
    cyc(1, 1, 8'hA1, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'(OVF_EN));
    cyc(1, 0, 8'h00, 0, 0, 1);
    chk("ovf_clr", 32'(ovf), 32'd0);
    cyc(1, 1, 8'hA2, 0, 0, 1);
    chk("ovf_set_wins", 32'(ovf), 32'(OVF_EN));
    cyc(1, 0, 8'h00, 0, 1, 0);
    chk("ovf_vs_flush", 32'(ovf), 32'(OVF_EN));
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(8'h80 + i), 0, 0, 0);
    cyc(1, 1, 8'hA3, 1, 0, 0);
    chk("full_pushpop_level", 32'(level), 32'(DEPTH - 1));
    chk("full_pushpop_head", 32'(tx_data), 32'h81);

    // Mid-stream reset, then a fresh push.
    cyc(1, 0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'($urandom), 0, 0, 0);
    cyc(1, 1, 8'h99, 1, 1, 1);
    chk("pre_reset_level", 32'(level), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 8'($urandom), 0, 0, 0);
    cyc(0, 1, 8'h77, 1, 0, 0);
    chk("reset_level", 32'(level), 32'd0);
    cyc(1, 1, 8'h3C, 0, 0, 0);
    chk("post_reset_byte", 32'(tx_data), 32'h3C);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 99) < 60),
          8'($urandom),
          ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
